rob_queue: RTL
==============

Name: rob_queue

Overview:
- Parametrised circular reorder buffer between rename/dispatch and commit.
- Allocates up to DISPATCH_WIDTH entries per cycle in program order and marks them done from COMPLETE_PORTS execution writeback ports.
- Retires up to COMMIT_WIDTH oldest completed entries per cycle, driving the commit rename table and the physical-register free list.
- Flushes precisely on an exception at the head or on an external flush, and tracks macro-op boundaries for interrupt acceptance.

Parameters:
ENTRIES, 16, number of entries; power of two, >= 4.
DISPATCH_WIDTH, 2, allocation lanes per cycle.
COMPLETE_PORTS, 2, completion writeback ports.
COMMIT_WIDTH, 2, retirement lanes per cycle.
NUM_PREGS, 64, physical registers; PW = $clog2(NUM_PREGS).
NUM_AREGS, 32, architectural registers; AW = $clog2(NUM_AREGS); IW = $clog2(ENTRIES).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
alloc_valid  in  DISPATCH_WIDTH  per-lane allocate request; must be contiguous from lane 0
alloc_areg  in  DISPATCH_WIDTH*AW  destination architectural register per lane
alloc_preg  in  DISPATCH_WIDTH*PW  newly renamed physical register
alloc_old_preg  in  DISPATCH_WIDTH*PW  previous mapping of areg, freed at commit
alloc_mop_begin  in  DISPATCH_WIDTH  entry begins a macro-instruction
alloc_mop_end  in  DISPATCH_WIDTH  entry ends a macro-instruction
alloc_ready  out  1  allocation accepted this cycle
alloc_idx  out  DISPATCH_WIDTH*IW  entry index assigned to each lane (tail+lane mod ENTRIES)
complete_valid  in  COMPLETE_PORTS  completion strobe
complete_idx  in  COMPLETE_PORTS*IW  completing entry
complete_exc  in  COMPLETE_PORTS  completing entry raised an exception
commit_valid  out  COMMIT_WIDTH  lane retires this cycle
commit_areg  out  COMMIT_WIDTH*AW  retired areg
commit_preg  out  COMMIT_WIDTH*PW  retired preg (commit RAT write)
commit_old_preg  out  COMMIT_WIDTH*PW  preg to return to free list
flush  in  1  external squash of all entries
exc_valid  out  1  one-cycle pulse: precise exception taken
exc_idx  out  IW  faulting entry
exc_areg  out  AW  faulting entry's areg
interruptible  out  1  architectural state sits on a macro-op boundary
num_free  out  IW+1  free entries

Behaviour:
- Pointers head/tail are IW+1 bits with wrap bit. Occupancy = tail-head; num_free = ENTRIES-occupancy (combinational from registered pointers). Empty when head==tail; full when indices match and wrap bits differ.
- Per-entry state: valid, busy, exc, areg, preg, old_preg, mop_begin, mop_end.
- Reset: all valid/busy/exc cleared, head=tail=0, exc_valid=0, interruptible=1. Outputs: alloc_ready=1, num_free=ENTRIES, commit_valid=0.
- Allocation is all-or-nothing. alloc_ready = (num_free >= DISPATCH_WIDTH) && !kill, where kill = flush || head-exception.
- At an edge with alloc_ready, each valid lane k writes entry tail+k with valid=1, busy=1, exc=0. Tail advances by popcount(alloc_valid).
- Lanes are dropped when alloc_ready=0. Non-contiguous alloc_valid is illegal, and the bench asserts on it.
- Completion: at the edge, busy<=0 and exc<=complete_exc for entry complete_idx. Completion to a non-valid entry is ignored. Two ports naming the same entry in one cycle is illegal.
- Commit, combinational from registered state:
  - lane k is valid iff entries head..head+k are all valid, !busy and !exc, and k < occupancy.
  - The first busy or exc entry stops the scan.
  - At the edge, committed entries are cleared and head advances by the commit count.
  - No backpressure: consumers must accept.
- Same-cycle interactions:
  - Completion and commit see pre-edge state, so an entry completed in cycle N can commit in N+1 at the earliest.
  - num_free ignores same-cycle commits, which is conservative.
  - Allocation into a slot freed the same cycle is impossible.
- Head exception: head entry valid, !busy, exc=1.
  - In that cycle: commit_valid=0 and alloc_ready=0.
  - At the edge: all valid/busy/exc cleared and tail<=head.
  - Next cycle: exc_valid=1 for exactly one cycle, with exc_idx and exc_areg captured from the head entry.
  - Completions that cycle are discarded.
- External flush: same clearing as a head exception, but no exc_valid. flush overrides a simultaneous head exception (no pulse).
- interruptible (registered):
  - after a commit, set to the mop_end of the youngest committed lane;
  - set to 1 on flush or exception;
  - unchanged otherwise.
- Priority: reset > flush/exception > commit/complete/alloc.
- Reset asserted mid-operation discards all entries and in-flight completions in one cycle.

Test Plan:
- Reset, then 2 lanes/cycle for 8 cycles with no completions -> alloc_idx 0,1..14,15; num_free 16→0; alloc_ready=0 once num_free<2.
- Fill 4 entries, complete idx 2,0,1,3 out of order -> commit_valid=01 (idx0), then 11 (1,2), then 01 (3), each one cycle after the enabling completion; commit_old_preg matches the allocated values.
- Complete idx 1 with exc=1 while idx 0 is busy, then complete idx 0 -> idx0 commits; next cycle no commit, entries cleared; following cycle exc_valid=1, exc_idx=1; num_free=16.
- Wrap-around: ENTRIES=16, head=tail=14, allocate 4 and complete all -> idx 14,15,0,1 commit in order; wrap bit toggles, num_free returns to 16.
- Commit mop_begin/mop_end pairs -> interruptible=0 after a begin-only commit, 1 after the end commit. Assert flush with a pending head exception -> no exc_valid, interruptible=1.
- Assert reset while 6 entries are busy and completions are in flight -> next cycle num_free=16, commit_valid=0, exc_valid=0, alloc_idx lane0=0.

Source files
------------

// File: rtl/rob_queue.sv
// Circular reorder buffer: in-order allocate, out-of-order complete, in-order retire of up to COMMIT_WIDTH per cycle.
// Commit is combinational from registered state; allocation is all-or-nothing with alloc_ready as the only backpressure.
module rob_queue #(
    parameter int ENTRIES        = 16,
    parameter int DISPATCH_WIDTH = 2,
    parameter int COMPLETE_PORTS = 2,
    parameter int COMMIT_WIDTH   = 2,
    parameter int NUM_PREGS      = 64,
    parameter int NUM_AREGS      = 32,
    localparam int PW = $clog2(NUM_PREGS),
    localparam int AW = $clog2(NUM_AREGS),
    localparam int IW = $clog2(ENTRIES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DISPATCH_WIDTH-1:0]    alloc_valid,
    input  logic [DISPATCH_WIDTH*AW-1:0] alloc_areg,
    input  logic [DISPATCH_WIDTH*PW-1:0] alloc_preg,
    input  logic [DISPATCH_WIDTH*PW-1:0] alloc_old_preg,
    input  logic [DISPATCH_WIDTH-1:0]    alloc_mop_begin,
    input  logic [DISPATCH_WIDTH-1:0]    alloc_mop_end,
    output logic                         alloc_ready,
    output logic [DISPATCH_WIDTH*IW-1:0] alloc_idx,
    input  logic [COMPLETE_PORTS-1:0]    complete_valid,
    input  logic [COMPLETE_PORTS*IW-1:0] complete_idx,
    input  logic [COMPLETE_PORTS-1:0]    complete_exc,
    output logic [COMMIT_WIDTH-1:0]      commit_valid,
    output logic [COMMIT_WIDTH*AW-1:0]   commit_areg,
    output logic [COMMIT_WIDTH*PW-1:0]   commit_preg,
    output logic [COMMIT_WIDTH*PW-1:0]   commit_old_preg,
    input  logic                         flush,
    output logic                         exc_valid,
    output logic [IW-1:0]                exc_idx,
    output logic [AW-1:0]                exc_areg,
    output logic                         interruptible,
    output logic [IW:0]                  num_free
);

    typedef struct packed {
        logic          valid;
        logic          busy;
        logic          exc;
        logic [AW-1:0] areg;
        logic [PW-1:0] preg;
        logic [PW-1:0] old_preg;
        logic          mop_begin;
        logic          mop_end;
    } entry_t;

    localparam logic [IW:0] DEPTH   = (IW+1)'(ENTRIES);
    localparam logic [IW:0] DW_NEED = (IW+1)'(DISPATCH_WIDTH);

    entry_t        ent [ENTRIES];
    logic [IW:0]   head, tail, occupancy, alloc_cnt, commit_cnt;
    logic [IW-1:0] head_slot;
    logic [IW-1:0] commit_slot [COMMIT_WIDTH];
    logic          head_exc, kill, commit_last_end, scan_run;
    logic          unused_mop_begin;

    assign head_slot   = head[IW-1:0];
    assign occupancy   = tail - head;
    assign num_free    = DEPTH - occupancy;
    assign head_exc    = ent[head_slot].valid && !ent[head_slot].busy && ent[head_slot].exc;
    assign kill        = flush || head_exc;
    assign alloc_ready = (num_free >= DW_NEED) && !kill;

    always_comb begin
        alloc_idx = '0;
        alloc_cnt = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            alloc_idx[k*IW +: IW] = tail[IW-1:0] + IW'(k);
            alloc_cnt = alloc_cnt + (IW+1)'(alloc_valid[k]);
        end
    end

    // In-order scan from head; the first busy/excepting/empty slot ends the retire group.
    always_comb begin
        commit_valid    = '0;
        commit_areg     = '0;
        commit_preg     = '0;
        commit_old_preg = '0;
        commit_cnt      = '0;
        commit_last_end = 1'b0;
        scan_run        = !flush;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            commit_slot[k] = head_slot + IW'(k);
            if (scan_run && ((IW+1)'(k) < occupancy) && ent[commit_slot[k]].valid &&
                !ent[commit_slot[k]].busy && !ent[commit_slot[k]].exc) begin
                commit_valid[k]               = 1'b1;
                commit_areg[k*AW +: AW]       = ent[commit_slot[k]].areg;
                commit_preg[k*PW +: PW]       = ent[commit_slot[k]].preg;
                commit_old_preg[k*PW +: PW]   = ent[commit_slot[k]].old_preg;
                commit_cnt                    = commit_cnt + (IW+1)'(1);
                commit_last_end               = ent[commit_slot[k]].mop_end;
            end else begin
                scan_run = 1'b0;
            end
        end
    end

    always_comb begin
        unused_mop_begin = 1'b0;
        for (int i = 0; i < ENTRIES; i++) unused_mop_begin = unused_mop_begin ^ ent[i].mop_begin;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
            head          <= '0;
            tail          <= '0;
            exc_valid     <= 1'b0;
            exc_idx       <= '0;
            exc_areg      <= '0;
            interruptible <= 1'b1;
        end else if (kill) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent[i].valid <= 1'b0;
                ent[i].busy  <= 1'b0;
                ent[i].exc   <= 1'b0;
            end
            tail          <= head;
            exc_valid     <= !flush;
            interruptible <= 1'b1;
            if (!flush) begin
                exc_idx  <= head_slot;
                exc_areg <= ent[head_slot].areg;
            end
        end else begin
            exc_valid <= 1'b0;
            for (int p = 0; p < COMPLETE_PORTS; p++) begin
                if (complete_valid[p] && ent[complete_idx[p*IW +: IW]].valid) begin
                    ent[complete_idx[p*IW +: IW]].busy <= 1'b0;
                    ent[complete_idx[p*IW +: IW]].exc  <= complete_exc[p];
                end
            end
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (commit_valid[k]) begin
                    ent[commit_slot[k]].valid <= 1'b0;
                    ent[commit_slot[k]].busy  <= 1'b0;
                    ent[commit_slot[k]].exc   <= 1'b0;
                end
            end
            if (alloc_ready) begin
                for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                    if (alloc_valid[k]) begin
                        ent[alloc_idx[k*IW +: IW]] <= '{
                            valid:     1'b1,
                            busy:      1'b1,
                            exc:       1'b0,
                            areg:      alloc_areg[k*AW +: AW],
                            preg:      alloc_preg[k*PW +: PW],
                            old_preg:  alloc_old_preg[k*PW +: PW],
                            mop_begin: alloc_mop_begin[k],
                            mop_end:   alloc_mop_end[k]
                        };
                    end
                end
                tail <= tail + alloc_cnt;
            end
            head <= head + commit_cnt;
            if (commit_cnt != '0) interruptible <= commit_last_end;
        end
    end

endmodule
